// File: rtl/lock_sequencer.sv
// ============================================================================
// Module      : lock_sequencer
// Description : Control FSM for the switch/button combination lock. Detects
//               single-button presses, collects four BCD digits, checks them
//               against CODE, and runs the per-second countdowns for
//               auto-relock, entry timeout and lockout. Drives the display
//               mode and digit word of the seven-segment scanner.
//               Optional macro LOCK_DIGIT_MASK_EN: accepted digits are shown
//               as 4'hE in ENTRY/CHECK instead of their true value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_sequencer #(
  parameter logic [15:0] CODE         = 16'h1234,
  parameter logic [2:0]  MAX_TRIES    = 3'd3,
  parameter logic [4:0]  UNLOCK_SECS  = 5'd10,
  parameter logic [4:0]  LOCKOUT_SECS = 5'd10,
  parameter logic [4:0]  ENTRY_SECS   = 5'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sec_tick,
  input  logic [3:0]  btns,
  input  logic [3:0]  sw,
  output logic [1:0]  disp_mode,
  output logic [15:0] disp_digits,
  output logic        unlocked,
  output logic [2:0]  fail_cnt,
  output logic [4:0]  secs_left
);

  localparam logic [2:0] S_LOCKED   = 3'd0;
  localparam logic [2:0] S_ENTRY    = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_UNLOCKED = 3'd3;
  localparam logic [2:0] S_PAUSED   = 3'd4;

  localparam logic [15:0] BLANK = 16'hFFFF;

  // Button bit positions
  localparam int B_ENTER = 0;
  localparam int B_CLEAR = 1;
  localparam int B_LOCK  = 2;
  localparam int B_START = 3;

  logic [2:0]  state_q, state_d;
  logic [3:0]  prev_btns_q;
  logic [3:0]  press_q;
  logic [15:0] buf_q, buf_d;
  logic [1:0]  pos_q, pos_d;
  logic [4:0]  secs_q, secs_d;
  logic [2:0]  fail_q, fail_d;
  logic [1:0]  disp_mode_q, disp_mode_d;
  logic [15:0] disp_digits_q, disp_digits_d;
  logic        unlocked_q, unlocked_d;

  logic [2:0]  w_fail_inc;
  logic [3:0]  w_tens;
  logic [3:0]  w_ones;
  logic [15:0] w_entry_view;

  // Press detection: a one-hot value appearing after an all-released cycle
  // yields a single-cycle press pulse, consumed by the FSM one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_btns_q <= 4'b0000;
      press_q     <= 4'b0000;
    end else begin
      prev_btns_q <= btns;
      press_q     <= ((prev_btns_q == 4'b0000) && $onehot(btns)) ? btns : 4'b0000;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LOCKED;
      buf_q         <= BLANK;
      pos_q         <= 2'd0;
      secs_q        <= 5'd0;
      fail_q        <= 3'd0;
      disp_mode_q   <= 2'b00;
      disp_digits_q <= BLANK;
      unlocked_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      pos_q         <= pos_d;
      secs_q        <= secs_d;
      fail_q        <= fail_d;
      disp_mode_q   <= disp_mode_d;
      disp_digits_q <= disp_digits_d;
      unlocked_q    <= unlocked_d;
    end
  end

  assign w_fail_inc = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;

  // Next-state and datapath update; a press always wins over a same-cycle tick.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pos_d   = pos_q;
    secs_d  = secs_q;
    fail_d  = fail_q;
    case (state_q)
      S_LOCKED: begin
        if (press_q[B_START]) begin
          state_d = S_ENTRY;
          buf_d   = BLANK;
          pos_d   = 2'd0;
          secs_d  = ENTRY_SECS;
        end
      end
      S_ENTRY: begin
        if (press_q[B_ENTER]) begin
          if (sw <= 4'd9) begin
            case (pos_q)
              2'd0:    buf_d[15:12] = sw;
              2'd1:    buf_d[11:8]  = sw;
              2'd2:    buf_d[7:4]   = sw;
              default: buf_d[3:0]   = sw;
            endcase
            pos_d  = pos_q + 2'd1;
            secs_d = ENTRY_SECS;
            if (pos_q == 2'd3) begin
              state_d = S_CHECK;
              pos_d   = 2'd0;
              secs_d  = 5'd0;
            end
          end
        end else if (press_q[B_CLEAR]) begin
          buf_d  = BLANK;
          pos_d  = 2'd0;
          secs_d = ENTRY_SECS;
        end else if (sec_tick) begin
          if (secs_q <= 5'd1) begin
            state_d = S_LOCKED;
            buf_d   = BLANK;
            pos_d   = 2'd0;
            secs_d  = 5'd0;
          end else begin
            secs_d = secs_q - 5'd1;
          end
        end
      end
      S_CHECK: begin
        buf_d = BLANK;
        pos_d = 2'd0;
        if (buf_q == CODE) begin
          state_d = S_UNLOCKED;
          fail_d  = 3'd0;
          secs_d  = UNLOCK_SECS;
        end else begin
          fail_d = w_fail_inc;
          if (w_fail_inc == MAX_TRIES) begin
            state_d = S_PAUSED;
            secs_d  = LOCKOUT_SECS;
          end else begin
            state_d = S_LOCKED;
            secs_d  = 5'd0;
          end
        end
      end
      S_UNLOCKED: begin
        if (press_q[B_LOCK]) begin
          state_d = S_LOCKED;
          secs_d  = 5'd0;
        end else if (sec_tick) begin
          if (secs_q <= 5'd1) begin
            state_d = S_LOCKED;
            secs_d  = 5'd0;
          end else begin
            secs_d = secs_q - 5'd1;
          end
        end
      end
      S_PAUSED: begin
        if (sec_tick) begin
          if (secs_q <= 5'd1) begin
            state_d = S_LOCKED;
            fail_d  = 3'd0;
            secs_d  = 5'd0;
          end else begin
            secs_d = secs_q - 5'd1;
          end
        end
      end
      default: begin
        state_d = S_LOCKED;
        buf_d   = BLANK;
        pos_d   = 2'd0;
        secs_d  = 5'd0;
      end
    endcase
  end

  // Output decode from the next state so registered outputs track state_q.
  always_comb begin
    disp_mode_d   = 2'b00;
    disp_digits_d = BLANK;
    unlocked_d    = 1'b0;
    w_tens        = 4'd0;
    w_ones        = 4'd0;
    w_entry_view  = buf_d;
`ifdef LOCK_DIGIT_MASK_EN
    for (int i = 0; i < 4; i++) begin
      w_entry_view[i*4 +: 4] = (buf_d[i*4 +: 4] == 4'hF) ? 4'hF : 4'hE;
    end
`endif
    if (secs_d >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(secs_d - 5'd30);
    end else if (secs_d >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(secs_d - 5'd20);
    end else if (secs_d >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(secs_d - 5'd10);
    end else begin
      w_ones = 4'(secs_d);
    end
    case (state_d)
      S_ENTRY, S_CHECK: begin
        disp_mode_d   = 2'b01;
        disp_digits_d = w_entry_view;
      end
      S_UNLOCKED: begin
        disp_mode_d = 2'b10;
        unlocked_d  = 1'b1;
      end
      S_PAUSED: begin
        disp_mode_d   = 2'b11;
        disp_digits_d = {8'hFF, w_tens, w_ones};
      end
      default: begin
        disp_mode_d = 2'b00;
      end
    endcase
  end

  assign disp_mode   = disp_mode_q;
  assign disp_digits = disp_digits_q;
  assign unlocked    = unlocked_q;
  assign fail_cnt    = fail_q;
  assign secs_left   = secs_q;

endmodule

`default_nettype wire

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Top-level control FSM for the switch/button combination lock.
- Takes button presses and switch-selected digit values and sequences the lock through locked, code entry, check, unlocked and lockout-pause.
- Drives a display mode code and a 16-bit digit word to the existing 4-digit seven-segment scanner.
- Owns the per-second countdowns for auto-relock, entry timeout and lockout.

Parameters:
- CODE, 16'h1234: unlock code, four BCD nibbles; first digit entered is [15:12].
- MAX_TRIES, 3: consecutive wrong codes that trigger PAUSED; range 1..7.
- UNLOCK_SECS, 10: auto-relock time in UNLOCKED; range 1..31.
- LOCKOUT_SECS, 10: lockout time in PAUSED; range 1..31.
- ENTRY_SECS, 10: inactivity timeout in ENTRY; range 1..31.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle pulse per second, synchronous to clk
- btns  in  4  synchronized, debounced button levels: [0] enter digit, [1] clear, [2] lock, [3] start
- sw  in  4  digit value to enter (binary 0..15)
- disp_mode  out  2  00 LOCKED text, 01 digits, 10 UNLOCKED text, 11 PAUSED text+digits
- disp_digits  out  16  four display nibbles; 4'hF = blank/minus
- unlocked  out  1  high only in UNLOCKED
- fail_cnt  out  3  consecutive wrong-code count
- secs_left  out  5  active countdown value; 0 when no countdown runs

Behaviour:
- Reset (async, rst_n=0):
  - state=LOCKED, disp_mode=00, disp_digits=16'hFFFF, unlocked=0, fail_cnt=0, secs_left=0.
  - Internal previous-button register is cleared.
- Press detection:
  - A press is a registered rising edge where the new btns value is exactly one-hot and the previous value was 4'b0000.
  - Multi-button values are ignored, and no new press is registered until btns returns to 0.
  - One press produces exactly one action; it is acted on the cycle after the edge.
- LOCKED:
  - Start press -> ENTRY. Digit buffer=16'hFFFF, pos=0, secs_left=ENTRY_SECS. Other presses are ignored.
- ENTRY (disp_mode=01):
  - Enter press with sw<=9: writes sw into nibble (3-pos), counting [15:12] first; pos increments and secs_left reloads to ENTRY_SECS.
  - Enter press with sw>9 is ignored; the timer is not reloaded.
  - Clear press: buffer=16'hFFFF, pos=0, secs_left reloads.
  - Once the 4th digit is accepted -> CHECK on the next cycle.
  - sec_tick decrements secs_left. When secs_left would reach 0 -> LOCKED, buffer cleared, fail_cnt unchanged.
  - A press in the same cycle as sec_tick takes priority; the tick is dropped.
- CHECK (exactly one cycle, disp_mode=01):
  - Buffer==CODE -> UNLOCKED: fail_cnt=0, secs_left=UNLOCK_SECS.
  - Otherwise fail_cnt+1. If the new count equals MAX_TRIES -> PAUSED with secs_left=LOCKOUT_SECS; else -> LOCKED.
  - fail_cnt saturates at 7.
- UNLOCKED (disp_mode=10, unlocked=1):
  - Lock press -> LOCKED.
  - sec_tick decrements secs_left; reaching 0 -> LOCKED.
  - Lock press wins over a simultaneous tick.
- PAUSED (disp_mode=11):
  - All presses are ignored.
  - disp_digits={8'hFF, tens, ones}, the BCD of secs_left (tens 0..3).
  - sec_tick decrements secs_left; reaching 0 -> LOCKED with fail_cnt=0.
- Buffer and display:
  - The buffer is cleared on every exit from ENTRY/CHECK.
  - disp_digits=16'hFFFF in LOCKED and UNLOCKED; it shows the buffer in ENTRY and CHECK.
  - secs_left=0 in LOCKED and CHECK.
- All outputs are registered. Reset asserted mid-operation aborts immediately to the reset state.

Optional Feature:
- Macro: LOCK_DIGIT_MASK_EN
- Defined: in ENTRY and CHECK, accepted digits display as nibble 4'hE (masked) and unentered positions as 4'hF; the comparison still uses the true digits.
- Undefined: the actual entered digits are displayed.

Test Plan:
- Reset, start, enter 1,2,3,4 -> disp_digits steps FFFF, 1FFF, 12FF, 123F, 1234. CHECK lasts 1 cycle, then UNLOCKED with unlocked=1, secs_left=10. Ten ticks -> LOCKED.
- Enter 1,2,3,5 three times -> fail_cnt 1, 2, 3; the third attempt goes to PAUSED with disp_digits=FF10. Presses are ignored while paused; after 10 ticks -> LOCKED with fail_cnt=0.
- In ENTRY, sw=4'hB with enter -> no change. Enter 7 then clear -> FFFF and pos=0. Enter 1234 -> UNLOCKED.
- btns=4'b0011, then 4'b0001 without passing through 0 -> no action. Holding btns[0] for 50 cycles -> exactly one digit accepted.
- In UNLOCKED with secs_left=1, sec_tick and lock press in the same cycle -> LOCKED. In ENTRY, 10 ticks with no press -> LOCKED with fail_cnt unchanged.
- Assert rst_n low asynchronously mid-ENTRY with 2 digits entered -> outputs take reset values immediately. After release, a start press shows FFFF. With LOCK_DIGIT_MASK_EN, entering 1 shows EFFF.
